// File: rtl/soc_uart_rx.sv
`default_nettype none
// soc_uart_rx: 8N1 serial receiver (LSB first, idle high) feeding a
// first-word-fall-through byte FIFO with a valid/ready read port.
module soc_uart_rx #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            rx_i,
  output logic [7:0]                      rdata_o,
  output logic                            rvalid_o,
  input  logic                            rready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_o,
  output logic                            frame_err_o,
  output logic                            overrun_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FILL_W       = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [FILL_W-1:0] DEPTH_VAL = FILL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer and edge detector
  logic       rx_meta;
  logic       rx_s;
  logic       rx_prev;
  logic [1:0] sync_vld;
  logic       armed;
  logic       fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      rx_meta  <= rx_i;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      sync_vld <= {sync_vld[0], 1'b1};
      // A line that was already low at reset release must be seen high
      // through the synchronizer before a falling edge may start a frame.
      if (sync_vld[1] && rx_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign fall = armed & rx_prev & ~rx_s;

  // Receive FSM
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift;
  logic [7:0]       shift_nxt;
  logic             tick;
  logic             stop_sample;

  assign tick = (cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    stop_sample = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            cnt_nxt     = BIT_LOAD;
            bit_idx_nxt = 3'd0;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_nxt = {rx_s, shift[7:1]};
          cnt_nxt   = BIT_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          stop_sample = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Receive FIFO
  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  rptr_next;
  logic [FILL_W-1:0] count;
  logic [7:0]        head;
  logic              pop;
  logic              push;
  logic              can_accept;
  logic              frame_err_q;
  logic              overrun_q;

  assign pop        = rvalid_o & rready_i;
  assign can_accept = (count < DEPTH_VAL) | pop;
  assign push       = stop_sample & rx_s & can_accept;
  assign rptr_next  = rptr + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr] <= shift;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      head        <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr_next;
      end
      case ({push, pop})
        2'b10:   count <= count + FILL_W'(1);
        2'b01:   count <= count - FILL_W'(1);
        default: count <= count;
      endcase
      // The head register holds the oldest entry so a write into the slot
      // being popped (full FIFO, push and pop together) cannot disturb it.
      if (pop) begin
        if (count > FILL_W'(1)) begin
          head <= mem[rptr_next];
        end else if (push) begin
          head <= shift;
        end
      end else if (push && (count == '0)) begin
        head <= shift;
      end
      frame_err_q <= stop_sample & ~rx_s;
      overrun_q   <= stop_sample & rx_s & ~can_accept;
    end
  end

  assign rdata_o     = head;
  assign rvalid_o    = (count != '0);
  assign fill_o      = count;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_uart_rx.sv
`default_nettype none
// tb_soc_uart_rx: directed bench for soc_uart_rx at default parameters,
// with a byte scoreboard queue filled on send and drained on pop.
module tb_soc_uart_rx;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid;
  logic [3:0] fill;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] q[$];

  soc_uart_rx dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .fill_o      (fill),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts right after a rising edge; leaves the line high, aligned the same way.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    int n;
    n = 0;
    exp = 8'h00;
    @(negedge clk);
    while (!rvalid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rvalid), 32'd1);
    if (q.size() > 0) exp = q.pop_front();
    check({tag, "_data"}, 32'(rdata), 32'(exp));
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] tmp;

    // Reset with the line held low
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_fill", 32'(fill), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (2500) @(posedge clk);
    #1;
    check("low_line_rvalid", 32'(rvalid), 32'h0);
    check("low_line_ferr_cnt", 32'(fe_cnt), 32'h0);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    // 0x55: latency to rvalid
    q.push_back(8'h55);
    n = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        do begin
          @(posedge clk);
          n++;
          #1;
        end while (!rvalid && n < 3000);
        check("lat_cycles", 32'(n), 32'd2064);
        check("lat_rdata", 32'(rdata), 32'h55);
        check("lat_fill", 32'(fill), 32'd1);
      end
    join
    pop_check("b55");
    check("b55_empty_rvalid", 32'(rvalid), 32'h0);
    check("b55_empty_fill", 32'(fill), 32'h0);

    // Short low glitch, then a good byte
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("glitch_rvalid", 32'(rvalid), 32'h0);
    check("glitch_ferr_cnt", 32'(fe_cnt), 32'h0);
    q.push_back(8'hA3);
    send_frame(8'hA3, 1'b1);
    pop_check("bA3");

    // Framing error, then a good byte
    send_frame(8'h0F, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("ferr_cnt", 32'(fe_cnt), 32'd1);
    check("ferr_fill", 32'(fill), 32'h0);
    check("ferr_ovr_cnt", 32'(ov_cnt), 32'h0);
    q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    pop_check("b81");

    // Nine back-to-back bytes with no reader
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      if (i == 7) begin
        check("fill8_fill", 32'(fill), 32'd8);
        check("fill8_ovr_cnt", 32'(ov_cnt), 32'h0);
      end
    end
    check("ovr_cnt", 32'(ov_cnt), 32'd1);
    check("ovr_fill", 32'(fill), 32'd8);

    // Full FIFO: pop in the same cycle as the stop sample
    fork
      send_frame(8'h08, 1'b1);
      begin
        repeat (2063) @(posedge clk);
        #1;
        rready = 1'b1;
        tmp = q.pop_front();
        check("simul_head", 32'(rdata), 32'(tmp));
        q.push_back(8'h08);
        @(posedge clk);
        #1;
        rready = 1'b0;
        check("simul_fill", 32'(fill), 32'd8);
      end
    join
    check("simul_ovr_cnt", 32'(ov_cnt), 32'd1);
    for (int i = 0; i < 8; i++) pop_check("drain");
    check("drain_fill", 32'(fill), 32'h0);

    // Asynchronous reset in the middle of a frame
    send_frame(8'h3C, 1'b1);
    check("pre_rst_fill", 32'(fill), 32'd1);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (1000) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_fill", 32'(fill), 32'h0);
        check("mid_rst_rvalid", 32'(rvalid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    repeat (50) @(posedge clk);
    #1;
    check("post_rst_fill", 32'(fill), 32'h0);
    check("post_rst_ferr_cnt", 32'(fe_cnt), 32'd1);
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    pop_check("b5A");
    check("final_fill", 32'(fill), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soc_uart_rx.md
# soc_uart_rx

Receive half of the SoC serial link: samples the asynchronous `ser_rx` line (8N1, LSB first, idle high), rebuilds bytes and buffers them in a small first-word-fall-through FIFO with a valid/ready read port. It sits inside `cv32e40x_soc` between the `ser_rx` pin and the peripheral bus register block, and mirrors the existing stdout transmitter: same `CLK_FREQ`/`BAUDRATE` parameters, same frame format.

## Interface

Parameters:
- `CLK_FREQ`, 25_000_000: system clock frequency in Hz.
- `BAUDRATE`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥ 2.
- Derived, not overridable: `CLKS_PER_BIT = CLK_FREQ / BAUDRATE` (integer division; 217 at defaults); `HALF_BIT = CLKS_PER_BIT / 2` (108).

Ports:
- `clk_i` in 1: system clock; the block's only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `rx_i` in 1: serial input, asynchronous to `clk_i`, idle high.
- `rdata_o` out 8: byte at the FIFO head; valid while `rvalid_o` is high.
- `rvalid_o` out 1: FIFO not empty.
- `rready_i` in 1: consumer accepts the head byte; a pop occurs when `rvalid_o && rready_i`.
- `fill_o` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.
- `frame_err_o` out 1: one-cycle pulse; the stop bit sampled low.
- `overrun_o` out 1: one-cycle pulse; a good byte was dropped because the FIFO was full.

## Operation

- Synchronizer: two flops on `rx_i` produce `rx_s`; both reset to 1. A third flop holds the previous `rx_s` for edge detection.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a 1→0 transition of `rx_s`, load the bit counter and enter START. A line that is already low does not trigger a frame.
  - START: after `HALF_BIT` cycles, sample `rx_s`. If it is 1, the start was false: go to IDLE with no output. If it is 0, enter DATA.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 samples, shifted in LSB first. After the 8th sample, enter STOP.
  - STOP: `CLKS_PER_BIT` cycles later, sample the stop bit and go to IDLE in the next cycle.
    - Stop = 1 and the FIFO can accept: push the byte.
    - Stop = 1 and the FIFO is full: drop the byte and pulse `overrun_o`.
    - Stop = 0: drop the byte and pulse `frame_err_o`. `overrun_o` does not pulse.
- The FIFO can accept when `fill_o < FIFO_DEPTH`, or when a pop occurs in the same cycle. A simultaneous push and pop leaves `fill_o` unchanged.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. A pop when empty is ignored.
- Break condition (line held low): the first frame ends with `frame_err_o`. No further frames start until `rx_s` returns high and falls again.
- Reset: asserting `rst_i` mid-frame aborts the frame, empties the FIFO and returns the FSM to IDLE, independent of `clk_i`.

## Timing

- Reset values: `rdata_o` = 0, `rvalid_o` = 0, `fill_o` = 0, `frame_err_o` = 0, `overrun_o` = 0. FSM in IDLE; synchronizer flops = 1.
- Input latency: 2 cycles from `rx_i` to `rx_s`.
- Sample points, counted from the cycle the falling edge is detected on `rx_s` (cycle 0):
  - start bit at cycle `HALF_BIT`;
  - data bit k (k = 0..7) at cycle `HALF_BIT + (k+1)*CLKS_PER_BIT`;
  - stop bit at cycle `HALF_BIT + 9*CLKS_PER_BIT` (2061 at defaults).
- Push takes effect on the stop-sample edge. `rvalid_o` and `fill_o` update in the following cycle, and `frame_err_o`/`overrun_o` are high for exactly that cycle.
- `rdata_o` changes only on a pop or on a push into an empty FIFO. The new head is visible the cycle after a pop.
- Throughput: back-to-back frames at the full line rate with no idle gap. Baud error up to ±2 % is tolerated.

## Test plan

- Reset → all outputs 0. Drive `rx_i` low during reset and release reset with the line still low → no frame is detected until the line goes high and then falls.
- Send 0x55 at 217 clocks/bit → `rvalid_o` rises exactly 2 + 2061 + 1 cycles after the `rx_i` falling edge, with `rdata_o` = 0x55 and `fill_o` = 1. Pop with `rready_i` → `rvalid_o` = 0 and `fill_o` = 0.
- Send a 50-cycle low glitch → no push and no error pulse; FSM back in IDLE. Then send 0xA3 → `rdata_o` = 0xA3.
- Send 0x0F with the stop bit low → `frame_err_o` is high for 1 cycle, `fill_o` stays 0. A following good frame 0x81 is received normally.
- With `rready_i` = 0, send 9 bytes 0x00..0x08 back-to-back → `fill_o` = 8 and `overrun_o` pulses once, on the 9th byte. Drain → reads 0x00..0x07 in order.
- With the FIFO full, assert `rready_i` in the same cycle as the 9th stop sample → byte 0x08 is accepted, `overrun_o` = 0, `fill_o` stays 8. Assert `rst_i` mid-frame → FIFO empties and the FSM is in IDLE immediately.
